// File: rtl/tpsram_pkg.sv
// Shared types and helpers for the byte-write two-port RAM with output pipeline.
package tpsram_pkg;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   localparam int ADDR_WIDTH_DEF = 9;
   localparam int DEPTH          = 2**ADDR_WIDTH_DEF;

   function automatic int num_lanes(input int data_width, input int byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/tpsram_core.sv
// Behavioural simple dual-port array: per-lane write, registered raw read.
// Kept minimal so synthesis maps it onto block RAM with byte enables.
module tpsram_core
   import tpsram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9,
   parameter int BYTE_WIDTH = 8,
   localparam int LANES     = num_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [LANES-1:0]      be,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic                  ren,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rd
);

   localparam int WORDS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
               mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wd[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // Read-first raw port; the output register's sync reset maps onto the RAM primitive.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd <= '0;
      end else if (ren) begin
         rd <= mem[raddr];
      end
   end

endmodule

// File: rtl/tpsram_bytewr_pipe.sv
// Byte-write two-port RAM with post-reset clear, write-first forwarding and
// optional output register, between the LVDS packer and the frame readout.
module tpsram_bytewr_pipe
   import tpsram_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter int BYTE_WIDTH     = 8,
   parameter int OUT_REG        = 1,
   parameter int CLEAR_ON_RESET = 1,
   localparam int LANES         = num_lanes(DATA_WIDTH, BYTE_WIDTH)
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic [DATA_WIDTH-1:0] WD,
   input  logic [ADDR_WIDTH-1:0] WADDR,
   input  logic                  WEN,
   input  logic [LANES-1:0]      WBE,
   input  logic [ADDR_WIDTH-1:0] RADDR,
   input  logic                  REN,
   output logic [DATA_WIDTH-1:0] RD,
   output logic                  RD_VALID,
   output logic                  BUSY
);

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $error("tpsram_bytewr_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end
   if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_out_reg
      $error("tpsram_bytewr_pipe: OUT_REG must be 0 or 1");
   end

   state_t                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  busy_q;

   // Clear sequencer: one zero word per cycle, then READY until the next reset.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt <= '0;
         busy_q  <= 1'b1;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == '1) begin
                  state  <= ST_READY;
                  busy_q <= 1'b0;
               end
            end
            default: busy_q <= 1'b0;
         endcase
      end
   end

   logic clearing, user_wr, user_rd;

   assign clearing = (state == ST_CLEAR);
   assign user_wr  = RESET_N && !busy_q && WEN;
   assign user_rd  = RESET_N && !busy_q && REN;
   assign BUSY     = busy_q;

   logic [DATA_WIDTH-1:0] raw_rd;

   tpsram_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_core (
      .clk   (CLK),
      .rst_n (RESET_N),
      .we    (RESET_N && (clearing || user_wr)),
      .be    (clearing ? {LANES{1'b1}} : WBE),
      .waddr (clearing ? clr_cnt : WADDR),
      .wd    (clearing ? {DATA_WIDTH{1'b0}} : WD),
      .ren   (user_rd),
      .raddr (RADDR),
      .rd    (raw_rd)
   );

   logic                  s1_valid;
   logic [LANES-1:0]      fwd_mask;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic [DATA_WIDTH-1:0] s1_data;

   // The array returns the old word on a same-address collision, so the new
   // lanes are remembered here and patched over it to give write-first data.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         s1_valid <= 1'b0;
         fwd_mask <= '0;
         fwd_data <= '0;
      end else begin
         s1_valid <= user_rd;
         if (user_rd) begin
            fwd_mask <= (user_wr && (WADDR == RADDR)) ? WBE : '0;
            fwd_data <= WD;
         end
      end
   end

   always_comb begin
      s1_data = raw_rd;
      for (int i = 0; i < LANES; i++) begin
         if (fwd_mask[i]) begin
            s1_data[i*BYTE_WIDTH +: BYTE_WIDTH] = fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   if (OUT_REG == 0) begin : g_lat1
      assign RD       = s1_data;
      assign RD_VALID = s1_valid;
   end else begin : g_lat2
      logic [DATA_WIDTH-1:0] out_q;
      logic                  out_valid_q;

      always_ff @(posedge CLK) begin
         if (!RESET_N) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
               out_q <= s1_data;
            end
         end
      end

      assign RD       = out_q;
      assign RD_VALID = out_valid_q;
   end

endmodule

// File: tb/tb_tpsram_bytewr_pipe.sv
// Bench for tpsram_bytewr_pipe: latency-1 and latency-2 instances share stimulus
// and are checked against a word-array reference model.
module tb_tpsram_bytewr_pipe;
   import tpsram_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic [31:0] WD;
   logic [8:0]  WADDR;
   logic        WEN;
   logic [3:0]  WBE;
   logic [8:0]  RADDR;
   logic        REN;

   logic [31:0] rd0, rd1;
   logic        rv0, rv1, busy0, busy1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   tpsram_bytewr_pipe #(.OUT_REG(0)) dut0 (
      .CLK(CLK), .RESET_N(RESET_N), .WD(WD), .WADDR(WADDR), .WEN(WEN), .WBE(WBE),
      .RADDR(RADDR), .REN(REN), .RD(rd0), .RD_VALID(rv0), .BUSY(busy0)
   );

   tpsram_bytewr_pipe #(.OUT_REG(1)) dut1 (
      .CLK(CLK), .RESET_N(RESET_N), .WD(WD), .WADDR(WADDR), .WEN(WEN), .WBE(WBE),
      .RADDR(RADDR), .REN(REN), .RD(rd1), .RD_VALID(rv1), .BUSY(busy1)
   );

   // Reference model: plain word array, cycles left in the clear, and the
   // expected visible RD/RD_VALID for one- and two-cycle read latency.
   logic [31:0] model_mem [DEPTH];
   int          clear_left = DEPTH;
   logic        e1_valid, e2_valid, pend_valid;
   logic [31:0] e1_rd, e2_rd, pend_data;

   task automatic do_cycle(input logic rst_n, input logic wen, input logic [8:0] waddr,
                           input logic [31:0] wd, input logic [3:0] wbe,
                           input logic ren, input logic [8:0] raddr);
      logic        accepted, hit;
      logic [31:0] rval;
      RESET_N = rst_n; WEN = wen; WADDR = waddr; WD = wd; WBE = wbe; REN = ren; RADDR = raddr;
      @(posedge CLK);
      hit  = 1'b0;
      rval = '0;
      if (!rst_n) begin
         clear_left = DEPTH;
         pend_valid = 1'b0;
         e1_valid = 1'b0; e1_rd = '0;
         e2_valid = 1'b0; e2_rd = '0;
      end else begin
         accepted = (clear_left == 0);
         if (!accepted) begin
            model_mem[DEPTH - clear_left] = '0;
            clear_left--;
         end
         if (accepted && ren) begin
            hit  = 1'b1;
            rval = model_mem[raddr];
            if (wen && waddr == raddr)
               for (int l = 0; l < 4; l++) if (wbe[l]) rval[l*8 +: 8] = wd[l*8 +: 8];
         end
         if (accepted && wen)
            for (int l = 0; l < 4; l++) if (wbe[l]) model_mem[waddr][l*8 +: 8] = wd[l*8 +: 8];
         e2_valid = pend_valid;
         if (pend_valid) e2_rd = pend_data;
         pend_valid = hit;
         if (hit) pend_data = rval;
         e1_valid = hit;
         if (hit) e1_rd = rval;
      end
      #1;
   endtask

   task automatic do_idle(input int n);
      for (int k = 0; k < n; k++) do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
   endtask

   task automatic test_reset;
      int busy_cnt, guard, n0, n1, bad;
      logic saw_valid;
      do_cycle(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
      do_cycle(1'b0, 1'b1, 9'h3, 32'h1234, 4'hF, 1'b1, 9'h3);
      n_checks++; if (busy1 !== 1'b1) $display("[TB] FAIL reset_busy: got %b want 1", busy1); else n_pass++;
      n_checks++; if (rv0 !== 1'b0) $display("[TB] FAIL reset_rv0: got %b want 0", rv0); else n_pass++;
      n_checks++; if (rv1 !== 1'b0) $display("[TB] FAIL reset_rv1: got %b want 0", rv1); else n_pass++;
      n_checks++; if (rd0 !== 32'h0) $display("[TB] FAIL reset_rd0: got %h want 0", rd0); else n_pass++;
      n_checks++; if (rd1 !== 32'h0) $display("[TB] FAIL reset_rd1: got %h want 0", rd1); else n_pass++;
      busy_cnt  = busy1 ? 1 : 0;
      guard     = 0;
      saw_valid = 1'b0;
      while (busy1 && guard < 2000) begin
         do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'($urandom_range(0, 511)));
         if (busy1) busy_cnt++;
         if (rv0 || rv1) saw_valid = 1'b1;
         guard++;
      end
      n_checks++; if (busy_cnt != DEPTH) $display("[TB] FAIL clear_len: got %0d want %0d", busy_cnt, DEPTH); else n_pass++;
      n_checks++; if (saw_valid !== 1'b0) $display("[TB] FAIL clear_no_valid: got %b want 0", saw_valid); else n_pass++;
      n_checks++; if (busy0 !== 1'b0) $display("[TB] FAIL clear_busy0: got %b want 0", busy0); else n_pass++;
      n0 = 0; n1 = 0; bad = 0;
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'(i));
         if (rv0) n0++;
         if (rv1) n1++;
         if (rv0 && rd0 !== 32'h0) bad++;
         if (rv1 && rd1 !== 32'h0) bad++;
      end
      do_idle(1);
      if (rv1) n1++;
      if (rv0) n0++;
      n_checks++; if (n0 != DEPTH) $display("[TB] FAIL sweep_count0: got %0d want %0d", n0, DEPTH); else n_pass++;
      n_checks++; if (n1 != DEPTH) $display("[TB] FAIL sweep_count1: got %0d want %0d", n1, DEPTH); else n_pass++;
      n_checks++; if (bad != 0) $display("[TB] FAIL sweep_zero: got %0d nonzero words want 0", bad); else n_pass++;
   endtask

   task automatic test_basic;
      do_cycle(1'b1, 1'b1, 9'h1A5, 32'hDEADBEEF, 4'hF, 1'b0, 9'h0);
      do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h1A5);
      n_checks++; if (rv0 !== 1'b1) $display("[TB] FAIL basic_rv0: got %b want 1", rv0); else n_pass++;
      n_checks++; if (rd0 !== 32'hDEADBEEF) $display("[TB] FAIL basic_rd0: got %h want deadbeef", rd0); else n_pass++;
      n_checks++; if (rv1 !== 1'b0) $display("[TB] FAIL basic_rv1_early: got %b want 0", rv1); else n_pass++;
      do_idle(1);
      n_checks++; if (rv1 !== 1'b1) $display("[TB] FAIL basic_rv1: got %b want 1", rv1); else n_pass++;
      n_checks++; if (rd1 !== 32'hDEADBEEF) $display("[TB] FAIL basic_rd1: got %h want deadbeef", rd1); else n_pass++;
      n_checks++; if (rv0 !== 1'b0) $display("[TB] FAIL basic_rv0_pulse: got %b want 0", rv0); else n_pass++;
      n_checks++; if (rd0 !== 32'hDEADBEEF) $display("[TB] FAIL basic_rd0_hold: got %h want deadbeef", rd0); else n_pass++;
      do_idle(1);
      n_checks++; if (rv1 !== 1'b0) $display("[TB] FAIL basic_rv1_pulse: got %b want 0", rv1); else n_pass++;
      n_checks++; if (rd1 !== 32'hDEADBEEF) $display("[TB] FAIL basic_rd1_hold: got %h want deadbeef", rd1); else n_pass++;
   endtask

   task automatic test_byte_lanes;
      do_cycle(1'b1, 1'b1, 9'h010, 32'h11223344, 4'hF, 1'b0, 9'h0);
      do_cycle(1'b1, 1'b1, 9'h010, 32'hAABBCCDD, 4'b0101, 1'b0, 9'h0);
      do_cycle(1'b1, 1'b1, 9'h011, 32'hFFFFFFFF, 4'b0000, 1'b1, 9'h010);
      n_checks++; if (rd0 !== 32'h11BB33DD) $display("[TB] FAIL lanes_rd0: got %h want 11bb33dd", rd0); else n_pass++;
      do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'h011);
      n_checks++; if (rd1 !== 32'h11BB33DD) $display("[TB] FAIL lanes_rd1: got %h want 11bb33dd", rd1); else n_pass++;
      n_checks++; if (rd0 !== 32'h0) $display("[TB] FAIL lanes_wbe0_noop: got %h want 0", rd0); else n_pass++;
      do_idle(2);
   endtask

   task automatic test_forwarding;
      do_cycle(1'b1, 1'b1, 9'h020, 32'h11223344, 4'hF, 1'b0, 9'h0);
      do_cycle(1'b1, 1'b1, 9'h020, 32'h55667788, 4'b1100, 1'b1, 9'h020);
      n_checks++; if (rd0 !== 32'h55663344) $display("[TB] FAIL fwd_rd0: got %h want 55663344", rd0); else n_pass++;
      do_cycle(1'b1, 1'b1, 9'h021, 32'h99999999, 4'hF, 1'b1, 9'h020);
      n_checks++; if (rd1 !== 32'h55663344) $display("[TB] FAIL fwd_rd1: got %h want 55663344", rd1); else n_pass++;
      n_checks++; if (rd0 !== 32'h55663344) $display("[TB] FAIL fwd_later_rd0: got %h want 55663344", rd0); else n_pass++;
      do_idle(1);
      n_checks++; if (rd1 !== 32'h55663344) $display("[TB] FAIL fwd_later_rd1: got %h want 55663344", rd1); else n_pass++;
      do_idle(1);
   endtask

   task automatic test_reset_mid_clear;
      int busy_cnt, guard;
      logic [8:0] addrs [3];
      addrs[0] = 9'h1A5; addrs[1] = 9'h010; addrs[2] = 9'h020;
      do_cycle(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
      do_idle(300);
      n_checks++; if (busy1 !== 1'b1) $display("[TB] FAIL midclr_busy: got %b want 1", busy1); else n_pass++;
      do_cycle(1'b0, 1'b0, 9'h0, 32'h0, 4'h0, 1'b0, 9'h0);
      busy_cnt = busy1 ? 1 : 0;
      guard    = 0;
      while (busy1 && guard < 2000) begin
         do_idle(1);
         if (busy1) busy_cnt++;
         guard++;
      end
      n_checks++; if (busy_cnt != DEPTH) $display("[TB] FAIL midclr_len: got %0d want %0d", busy_cnt, DEPTH); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, addrs[i]);
         n_checks++; if (rv0 !== 1'b1 || rd0 !== 32'h0) $display("[TB] FAIL midclr_zero: addr %h got %b/%h want 1/0", addrs[i], rv0, rd0); else n_pass++;
      end
      do_idle(2);
   endtask

   task automatic test_streaming;
      for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b1, 9'(i), 32'(i), 4'hF, 1'b0, 9'h0);
      for (int i = 0; i < 8; i++) begin
         do_cycle(1'b1, 1'b0, 9'h0, 32'h0, 4'h0, 1'b1, 9'(i));
         n_checks++; if (rv0 !== 1'b1 || rd0 !== 32'(i)) $display("[TB] FAIL stream_lat1: beat %0d got %b/%h want 1/%h", i, rv0, rd0, 32'(i)); else n_pass++;
         if (i > 0) begin
            n_checks++; if (rv1 !== 1'b1 || rd1 !== 32'(i - 1)) $display("[TB] FAIL stream_lat2: beat %0d got %b/%h want 1/%h", i - 1, rv1, rd1, 32'(i - 1)); else n_pass++;
         end
      end
      do_idle(1);
      n_checks++; if (rv1 !== 1'b1 || rd1 !== 32'h7) $display("[TB] FAIL stream_last: got %b/%h want 1/7", rv1, rd1); else n_pass++;
      n_checks++; if (rv0 !== 1'b0) $display("[TB] FAIL stream_end0: got %b want 0", rv0); else n_pass++;
      do_idle(1);
      n_checks++; if (rv1 !== 1'b0) $display("[TB] FAIL stream_end1: got %b want 0", rv1); else n_pass++;
   endtask

   task automatic test_random;
      for (int c = 0; c < 400; c++) begin
         do_cycle(1'b1, 1'($urandom), 9'($urandom_range(0, 15)), $urandom, 4'($urandom),
                  1'($urandom), 9'($urandom_range(0, 15)));
         n_checks++; if (rv0 !== e1_valid) $display("[TB] FAIL rand_rv0: cyc %0d got %b want %b", c, rv0, e1_valid); else n_pass++;
         n_checks++; if (rd0 !== e1_rd) $display("[TB] FAIL rand_rd0: cyc %0d got %h want %h", c, rd0, e1_rd); else n_pass++;
         n_checks++; if (rv1 !== e2_valid) $display("[TB] FAIL rand_rv1: cyc %0d got %b want %b", c, rv1, e2_valid); else n_pass++;
         n_checks++; if (rd1 !== e2_rd) $display("[TB] FAIL rand_rd1: cyc %0d got %h want %h", c, rd1, e2_rd); else n_pass++;
      end
      do_idle(2);
   endtask

   initial begin
      RESET_N = 1'b0; WEN = 1'b0; REN = 1'b0; WD = '0; WADDR = '0; WBE = '0; RADDR = '0;
      e1_valid = 1'b0; e2_valid = 1'b0; pend_valid = 1'b0;
      e1_rd = '0; e2_rd = '0; pend_data = '0;
      test_reset();
      test_basic();
      test_byte_lanes();
      test_forwarding();
      test_reset_mid_clear();
      test_streaming();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tpsram_bytewr_pipe.md
Name: tpsram_bytewr_pipe

Overview:
Parametrised single-clock simple dual-port RAM for the LVDS datapath. It is the successor to the fixed 32x512 two-port SRAM macro.
- Adds byte-lane write enables, a read enable and a read-valid flag.
- Adds an optional output pipeline register and write-first read-during-write forwarding.
- Adds a post-reset clear sequencer that zeroes the whole array.
It sits between the LVDS deserialiser/packer (write side) and the frame readout logic (read side). Both sides run in the same clock domain.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per write-enable lane.
- OUT_REG, 1, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_ON_RESET, 1, 1 = zero the array after reset; 0 = skip the clear and go straight to READY.

Ports:
- CLK  in  1  single clock; all logic is on the rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- WD  in  DATA_WIDTH  write data.
- WADDR  in  ADDR_WIDTH  write address.
- WEN  in  1  write enable, active high.
- WBE  in  DATA_WIDTH/BYTE_WIDTH  byte-lane enables; bit i covers WD[i*BYTE_WIDTH +: BYTE_WIDTH].
- RADDR  in  ADDR_WIDTH  read address.
- REN  in  1  read enable, active high.
- RD  out  DATA_WIDTH  read data.
- RD_VALID  out  1  one-cycle pulse; RD is valid in the same cycle.
- BUSY  out  1  high while in reset or clearing; WEN and REN are ignored while high.

Behaviour:
- Reset: RESET_N sampled low at an edge gives
  - RD=0, RD_VALID=0, BUSY=1, all pipeline valids cleared;
  - FSM to CLEAR (CLEAR_ON_RESET=1) or READY (=0);
  - clear counter=0.
  Array contents are not changed by reset itself.
- FSM states: CLEAR, READY.
  - CLEAR: each cycle writes all-zero, all lanes, to address clr_cnt, then clr_cnt++.
  - When clr_cnt = 2**ADDR_WIDTH-1 has been written, go to READY. The clear takes exactly 2**ADDR_WIDTH cycles.
  - BUSY=1 throughout CLEAR; it drops to 0 in the first READY cycle.
  - READY: stay until reset.
- Reset asserted mid-clear restarts the clear from address 0.
- Write, READY only: WEN=1 at an edge writes the enabled lanes of WD into mem[WADDR]. Lanes whose WBE bit is 0 keep their old value. WBE=0 with WEN=1 is a no-op.
- Read, READY only: REN=1 at an edge captures mem[RADDR] into stage-1.
  - OUT_REG=0: RD/RD_VALID update on that edge (latency 1).
  - OUT_REG=1: stage-1 moves to the output register one edge later (latency 2).
  - Back-to-back reads give one result per cycle; there are no bubbles.
- RD holds its last value when no read completes. RD_VALID=0 in those cycles.
- Read-during-write, same address, same edge: write-first.
  - Enabled lanes return the new WD byte.
  - Disabled lanes return the stored byte.
  - Different addresses do not interact.
- REN or WEN asserted while BUSY=1 is dropped silently: no write, no RD_VALID.
- Elaboration checks: DATA_WIDTH % BYTE_WIDTH != 0, or OUT_REG not in {0,1}, gives an error.
- Addresses cover the full 2**ADDR_WIDTH range; no range check is needed.

Decomposition:
- Package tpsram_pkg holds:
  - state enum {ST_CLEAR, ST_READY};
  - function num_lanes(DATA_WIDTH, BYTE_WIDTH);
  - localparam DEPTH = 2**ADDR_WIDTH.
- Sub-module tpsram_core: behavioural array with per-lane write and registered raw read, written so synthesis infers RAM1K18 blocks.
- The top level holds the clear FSM/counter, write mux (clear vs user), forwarding compare, output pipeline and valid tracking.

Test Plan:
1. Reset, defaults: release RESET_N, then hold REN=1 -> BUSY=1 for exactly 512 cycles and no RD_VALID. After BUSY falls, read addresses 0..511 -> all RD=0x00000000, one RD_VALID each.
2. Basic write/read, OUT_REG=1: write 0xDEADBEEF to 0x1A5 with WBE=4'hF, then REN at 0x1A5 -> RD=0xDEADBEEF, RD_VALID high exactly 2 cycles after the REN edge. Repeat with OUT_REG=0 -> 1 cycle.
3. Byte lanes: write 0x11223344 (WBE=F) to 0x010, then write 0xAABBCCDD with WBE=4'b0101 -> read gives 0x11BB33DD.
4. Same-cycle same-address forwarding: array holds 0x11223344 at 0x020; WEN=REN=1 at 0x020 with WD=0x55667788 and WBE=4'b1100 -> RD=0x55663344. A later read also returns 0x55663344.
5. Reset mid-clear: assert RESET_N low for 1 cycle at clear count 300 -> BUSY stays high another full 512 cycles. Locations written before the first reset read back 0.
6. Streaming: REN=1 for 8 consecutive cycles over addresses 0..7, preloaded with 0..7 -> 8 consecutive RD_VALID pulses, RD=0..7 in order, no gaps.
